// File: rtl/secuenciador_chocorrol.sv
// Instruction sequencer for the chocorrol datapath.
// Host loads up to PROF words into a retained program buffer, then pulses
// i_inicio; each word is presented on o_instruccion for LAT cycles, with
// o_inst_valida on the first cycle of each slot. All outputs are registered,
// so they trail the internal state by one cycle.
//
// state  | meaning
// REPOSO | idle, accepts start and buffer writes
// EMITIR | first cycle of an instruction slot, reads buf[pc]
// ESPERA | remaining LAT-1 cycles of the slot, word held
// FIN    | one-cycle end of program, raises terminado
module secuenciador_chocorrol #(
    parameter int ANCHO_INST = 20,
    parameter int PROF       = 16,
    parameter int LAT        = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_carga_en,
    input  logic [$clog2(PROF)-1:0] i_carga_dir,
    input  logic [ANCHO_INST-1:0]   i_carga_dato,
    input  logic                    i_inicio,
    input  logic [$clog2(PROF):0]   i_num_inst,
    input  logic                    i_abortar,
    output logic [ANCHO_INST-1:0]   o_instruccion,
    output logic                    o_inst_valida,
    output logic [$clog2(PROF)-1:0] o_pc,
    output logic                    o_ocupado,
    output logic                    o_terminado,
    output logic                    o_error
);

    localparam int AW = $clog2(PROF);
    // Slot counter only has to reach LAT-2, so it never needs more than this.
    localparam int CW = (LAT > 2) ? $clog2(LAT - 1) : 1;
    localparam logic [AW:0]   PROF_L  = (AW + 1)'(PROF);
    localparam logic [AW:0]   UNO_LEN = (AW + 1)'(1);
    localparam logic [AW-1:0] UNO_PC  = AW'(1);
    localparam logic [CW-1:0] UNO_CNT = CW'(1);
    localparam logic [CW-1:0] CNT_ULT = CW'((LAT > 1) ? (LAT - 2) : 0);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        EMITIR = 2'd1,
        ESPERA = 2'd2,
        FIN    = 2'd3
    } estado_t;

    estado_t r_estado;
    estado_t w_estado_sig;

    logic [ANCHO_INST-1:0] r_buf [PROF];

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_sig;
    logic [AW:0]   r_len;
    logic [AW:0]   w_len_sig;
    logic [AW:0]   w_len_sat;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_sig;
    logic          r_aborto;
    logic          w_aborto_sig;

    logic [ANCHO_INST-1:0] r_instruccion;
    logic [ANCHO_INST-1:0] w_instruccion_sig;
    logic                  r_inst_valida;
    logic                  w_inst_valida_sig;
    logic [AW-1:0]         r_pc_o;
    logic [AW-1:0]         w_pc_o_sig;
    logic                  r_ocupado;
    logic                  w_ocupado_sig;
    logic                  r_terminado;
    logic                  w_terminado_sig;
    logic                  r_error;
    logic                  w_error_sig;

    logic w_escritura_ok;
    logic w_fin_slot;
    logic w_ultimo;

    // Writes are gated by the visible busy flag so the host sees a consistent rule.
    assign w_escritura_ok = i_carga_en & ~r_ocupado;
    assign w_len_sat      = (i_num_inst > PROF_L) ? PROF_L : i_num_inst;
    assign w_fin_slot     = ((LAT == 1) && (r_estado == EMITIR)) ||
                            ((LAT > 1) && (r_estado == ESPERA) && (r_cnt == CNT_ULT));
    assign w_ultimo       = ({1'b0, r_pc} == (r_len - UNO_LEN));

    // Program buffer: no reset, contents survive a reset of the control logic.
    always_ff @(posedge i_clk) begin
        if (w_escritura_ok) begin
            r_buf[i_carga_dir] <= i_carga_dato;
        end
    end

    // Next-state, slot bookkeeping and next values of the registered outputs.
    always_comb begin
        w_estado_sig      = r_estado;
        w_pc_sig          = r_pc;
        w_len_sig         = r_len;
        w_cnt_sig         = r_cnt;
        w_aborto_sig      = r_aborto;
        w_instruccion_sig = '0;
        w_inst_valida_sig = 1'b0;
        w_pc_o_sig        = r_pc_o;
        w_ocupado_sig     = 1'b0;
        w_terminado_sig   = 1'b0;
        w_error_sig       = (i_carga_en & r_ocupado) | (i_inicio & (r_estado != REPOSO));

        case (r_estado)
            REPOSO: begin
                if (i_inicio) begin
                    w_len_sig    = w_len_sat;
                    w_pc_sig     = '0;
                    w_cnt_sig    = '0;
                    w_aborto_sig = 1'b0;
                    w_estado_sig = (w_len_sat == '0) ? FIN : EMITIR;
                end
            end
            EMITIR, ESPERA: begin
                w_ocupado_sig = 1'b1;
                w_pc_o_sig    = r_pc;
                if (r_estado == EMITIR) begin
                    w_instruccion_sig = r_buf[r_pc];
                    w_inst_valida_sig = 1'b1;
                end else begin
                    w_instruccion_sig = r_instruccion;
                end
                // An abort request is remembered but only acted on at slot end.
                w_aborto_sig = r_aborto | i_abortar;
                if (w_fin_slot) begin
                    w_cnt_sig    = '0;
                    w_aborto_sig = 1'b0;
                    if (w_ultimo || r_aborto || i_abortar) begin
                        w_estado_sig = FIN;
                    end else begin
                        w_pc_sig     = r_pc + UNO_PC;
                        w_estado_sig = EMITIR;
                    end
                end else if (r_estado == EMITIR) begin
                    w_cnt_sig    = '0;
                    w_estado_sig = ESPERA;
                end else begin
                    w_cnt_sig = r_cnt + UNO_CNT;
                end
            end
            FIN: begin
                w_terminado_sig = 1'b1;
                w_pc_o_sig      = r_pc;
                w_estado_sig    = REPOSO;
            end
            default: begin
                w_estado_sig = REPOSO;
            end
        endcase
    end

    // State, sequencing registers and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_estado      <= REPOSO;
            r_pc          <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_aborto      <= 1'b0;
            r_instruccion <= '0;
            r_inst_valida <= 1'b0;
            r_pc_o        <= '0;
            r_ocupado     <= 1'b0;
            r_terminado   <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_estado      <= w_estado_sig;
            r_pc          <= w_pc_sig;
            r_len         <= w_len_sig;
            r_cnt         <= w_cnt_sig;
            r_aborto      <= w_aborto_sig;
            r_instruccion <= w_instruccion_sig;
            r_inst_valida <= w_inst_valida_sig;
            r_pc_o        <= w_pc_o_sig;
            r_ocupado     <= w_ocupado_sig;
            r_terminado   <= w_terminado_sig;
            r_error       <= w_error_sig;
        end
    end

    assign o_instruccion = r_instruccion;
    assign o_inst_valida = r_inst_valida;
    assign o_pc          = r_pc_o;
    assign o_ocupado     = r_ocupado;
    assign o_terminado   = r_terminado;
    assign o_error       = r_error;

endmodule

// File: tb/tb_secuenciador_chocorrol.sv
// Bench for secuenciador_chocorrol: a timeline model predicts every output
// for every cycle from the program contents and start/abort/reset events.
module tb_secuenciador_chocorrol;

    localparam int AI   = 20;
    localparam int PROF = 16;
    localparam int LAT  = 2;
    localparam int AW   = 4;
    localparam int N    = 1024;

    localparam logic [AI-1:0] W0 = 20'b1_00100_00000_00011_010;
    localparam logic [AI-1:0] W1 = 20'b1_00000_00100_00000_101;
    localparam logic [AI-1:0] W2 = 20'b0_00011_00000_00000_010;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_carga_en = 1'b0;
    logic [AW-1:0] i_carga_dir = '0;
    logic [AI-1:0] i_carga_dato = '0;
    logic          i_inicio = 1'b0;
    logic [AW:0]   i_num_inst = '0;
    logic          i_abortar = 1'b0;
    logic [AI-1:0] o_instruccion;
    logic          o_inst_valida;
    logic [AW-1:0] o_pc;
    logic          o_ocupado;
    logic          o_terminado;
    logic          o_error;

    secuenciador_chocorrol #(.ANCHO_INST(AI), .PROF(PROF), .LAT(LAT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_carga_en(i_carga_en), .i_carga_dir(i_carga_dir), .i_carga_dato(i_carga_dato),
        .i_inicio(i_inicio), .i_num_inst(i_num_inst), .i_abortar(i_abortar),
        .o_instruccion(o_instruccion), .o_inst_valida(o_inst_valida), .o_pc(o_pc),
        .o_ocupado(o_ocupado), .o_terminado(o_terminado), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cnt_valid = 0;
    int cnt_ocup = 0;
    int cnt_err = 0;

    // Expected outputs per cycle (cycle n = interval after rising edge n).
    bit [AI-1:0] e_instr [N];
    bit          e_valid [N];
    bit [AW-1:0] e_pc    [N];
    bit          e_ocup  [N];
    bit          e_term  [N];
    bit          e_err   [N];

    bit [AI-1:0] mbuf [PROF];
    bit [AI-1:0] snap [PROF];
    bit running = 1'b0;
    int rk = 0;
    int rl = 0;
    int mc;
    int slot;
    bit bad;
    bit busy_st;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Program run started at edge k with len words: lay out the whole timeline.
    task automatic schedule(input int k, input int len);
        for (int c = k + 1; c < N; c++) begin
            e_instr[c] = '0;
            e_valid[c] = 1'b0;
            e_ocup[c]  = 1'b0;
            e_term[c]  = 1'b0;
            e_pc[c]    = (len > 0) ? AW'(len - 1) : '0;
        end
        for (int i = 0; i < len; i++) begin
            for (int j = 0; j < LAT; j++) begin
                if (k + 1 + i * LAT + j < N) begin
                    e_instr[k + 1 + i * LAT + j] = snap[i];
                    e_valid[k + 1 + i * LAT + j] = (j == 0);
                    e_pc[k + 1 + i * LAT + j]    = AW'(i);
                    e_ocup[k + 1 + i * LAT + j]  = 1'b1;
                end
            end
        end
        if (k + 1 + len * LAT < N) e_term[k + 1 + len * LAT] = 1'b1;
    endtask

    task automatic model_reset();
        running = 1'b0;
        for (int c = cyc; c < N; c++) begin
            e_instr[c] = '0;
            e_valid[c] = 1'b0;
            e_ocup[c]  = 1'b0;
            e_term[c]  = 1'b0;
            e_err[c]   = 1'b0;
            e_pc[c]    = '0;
        end
    endtask

    // Model: looks at the inputs sampled on each rising edge.
    initial begin
        forever begin
            @(posedge i_clk);
            mc = cyc;
            if (!i_rst && mc < N - 1) begin
                bad = 1'b0;
                busy_st = running && (mc >= rk) && (mc <= rk + rl * LAT);
                if (i_carga_en) begin
                    if (e_ocup[mc]) bad = 1'b1;
                    else mbuf[i_carga_dir] = i_carga_dato;
                end
                if (i_abortar && running && mc >= rk && mc < rk + rl * LAT) begin
                    slot = (mc - rk) / LAT;
                    if (slot + 1 < rl) begin
                        rl = slot + 1;
                        schedule(rk, rl);
                    end
                end
                if (i_inicio) begin
                    if (busy_st) begin
                        bad = 1'b1;
                    end else begin
                        rk = mc + 1;
                        rl = (int'(i_num_inst) > PROF) ? PROF : int'(i_num_inst);
                        for (int i = 0; i < PROF; i++) snap[i] = mbuf[i];
                        running = 1'b1;
                        schedule(rk, rl);
                    end
                end
                if (bad) e_err[mc + 1] = 1'b1;
            end
            cyc = mc + 1;
        end
    end

    // Compare every output against the model on the falling edge.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && cyc < N) begin
                chk("instruccion", 32'(o_instruccion), 32'(e_instr[cyc]));
                chk("inst_valida", 32'(o_inst_valida), 32'(e_valid[cyc]));
                chk("pc",          32'(o_pc),          32'(e_pc[cyc]));
                chk("ocupado",     32'(o_ocupado),     32'(e_ocup[cyc]));
                chk("terminado",   32'(o_terminado),   32'(e_term[cyc]));
                chk("error",       32'(o_error),       32'(e_err[cyc]));
                cnt_valid += int'(o_inst_valida);
                cnt_ocup  += int'(o_ocupado);
                cnt_err   += int'(o_error);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [AI-1:0] d);
        i_carga_en   = 1'b1;
        i_carga_dir  = a;
        i_carga_dato = d;
        @(negedge i_clk);
        i_carga_en = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        i_num_inst = (AW + 1)'(n);
        i_inicio   = 1'b1;
        @(negedge i_clk);
        i_inicio = 1'b0;
    endtask

    task automatic wait_term(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_terminado) begin
                at = cyc;
                break;
            end
        end
        chk("terminado_seen", 32'(at >= 0), 32'd1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_instr"}, 32'(o_instruccion), 32'd0);
        chk({nm, "_valid"}, 32'(o_inst_valida), 32'd0);
        chk({nm, "_pc"},    32'(o_pc),          32'd0);
        chk({nm, "_ocup"},  32'(o_ocupado),     32'd0);
        chk({nm, "_term"},  32'(o_terminado),   32'd0);
        chk({nm, "_err"},   32'(o_error),       32'd0);
    endtask

    initial begin
        int k;
        int t;
        int v0;
        int o0;
        int e0;
        logic [AI-1:0] wd;

        repeat (3) @(negedge i_clk);
        chk_zero("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        for (int i = 0; i < PROF; i++) begin
            case (i)
                0:       wd = W0;
                1:       wd = W1;
                2:       wd = W2;
                default: wd = AI'(32'h10000 + i * 32'h111);
            endcase
            load(AW'(i), wd);
        end

        // Three-instruction program
        idle(2);
        o0 = cnt_ocup;
        pulse_start(3);
        k = cyc;
        @(negedge i_clk);
        chk("t1_valid0", 32'(o_inst_valida), 32'd1);
        chk("t1_instr0", 32'(o_instruccion), 32'(W0));
        chk("t1_pc0",    32'(o_pc), 32'd0);
        @(negedge i_clk);
        chk("t1_hold0",  32'(o_instruccion), 32'(W0));
        chk("t1_nvalid", 32'(o_inst_valida), 32'd0);
        @(negedge i_clk);
        chk("t1_instr1", 32'(o_instruccion), 32'(W1));
        chk("t1_pc1",    32'(o_pc), 32'd1);
        idle(2);
        chk("t1_instr2", 32'(o_instruccion), 32'(W2));
        chk("t1_pc2",    32'(o_pc), 32'd2);
        idle(2);
        chk("t1_term_cycle", 32'(cyc - k), 32'd7);
        chk("t1_term",   32'(o_terminado), 32'd1);
        chk("t1_instr_idle", 32'(o_instruccion), 32'd0);
        chk("t1_ocup_cycles", 32'(cnt_ocup - o0), 32'd6);

        // Empty program
        idle(2);
        v0 = cnt_valid;
        pulse_start(0);
        @(negedge i_clk);
        chk("t2_term", 32'(o_terminado), 32'd1);
        chk("t2_ocup", 32'(o_ocupado), 32'd0);
        chk("t2_pc",   32'(o_pc), 32'd0);
        chk("t2_valids", 32'(cnt_valid - v0), 32'd0);

        // Length saturates at buffer depth
        idle(2);
        v0 = cnt_valid;
        pulse_start(20);
        k = cyc;
        wait_term(60, t);
        chk("t3_term_cycle", 32'(t - k), 32'd33);
        chk("t3_pc_last", 32'(o_pc), 32'd15);
        chk("t3_valids", 32'(cnt_valid - v0), 32'd16);

        // Write and start while busy are rejected
        idle(2);
        e0 = cnt_err;
        pulse_start(3);
        idle(2);
        i_carga_en   = 1'b1;
        i_carga_dir  = AW'(1);
        i_carga_dato = 20'hFFFFF;
        @(negedge i_clk);
        i_carga_en = 1'b0;
        @(negedge i_clk);
        i_inicio = 1'b1;
        @(negedge i_clk);
        i_inicio = 1'b0;
        wait_term(20, t);
        chk("t4_err_pulses", 32'(cnt_err - e0), 32'd2);
        idle(2);
        pulse_start(3);
        idle(3);
        chk("t4_buf1_kept", 32'(o_instruccion), 32'(W1));
        wait_term(20, t);

        // Abort during slot 1 of a five-word program
        idle(2);
        v0 = cnt_valid;
        pulse_start(5);
        k = cyc;
        idle(3);
        i_abortar = 1'b1;
        @(negedge i_clk);
        i_abortar = 1'b0;
        wait_term(20, t);
        chk("t5_term_cycle", 32'(t - k), 32'd5);
        chk("t5_pc", 32'(o_pc), 32'd1);
        chk("t5_valids", 32'(cnt_valid - v0), 32'd2);

        // Reset in the middle of slot 2, then rerun without reloading
        idle(2);
        pulse_start(3);
        idle(5);
        #2;
        i_rst = 1'b1;
        model_reset();
        #1;
        chk_zero("t6_async");
        @(negedge i_clk);
        i_rst = 1'b0;
        idle(2);
        pulse_start(3);
        k = cyc;
        @(negedge i_clk);
        chk("t6_instr0", 32'(o_instruccion), 32'(W0));
        idle(2);
        chk("t6_instr1", 32'(o_instruccion), 32'(W1));
        idle(2);
        chk("t6_instr2", 32'(o_instruccion), 32'(W2));
        wait_term(10, t);
        chk("t6_term_cycle", 32'(t - k), 32'd7);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
